// File: rtl/mem_stage_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ext
// Description : MEM pipeline stage for the pipelined MIPS core. Holds the
//               E->M pipeline register and a DEPTH-word little-endian data
//               memory. Supports byte/half/word loads and stores with sign or
//               zero extension, a configurable multi-cycle access latency
//               with a stall request, bubble insertion and misalignment
//               detection.
// Ports       : CLK, RST               clock, synchronous active-high reset
//               *E inputs              control/data from the execute stage
//               FlushM                 load a bubble into the M register
//               RegWriteM, MemtoRegM,
//               ALUOutM, WriteRegM     registered values towards writeback
//               RD                     extended load data
//               MemBusy                stall request to earlier stages
//               MisalignM              instruction in M is misaligned
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage_ext #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [1:0]  MemSizeE,
    input  logic        MemSignedE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  WriteRegE,
    input  logic        FlushM,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic [31:0] RD,
    output logic        MemBusy,
    output logic        MisalignM
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    // A zero-latency build still needs a 1-bit counter to stay legal.
    localparam int c_CNT_W  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_LAT_MAX = c_CNT_W'(LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // M pipeline register
    logic               r_regwrite;
    logic               r_memtoreg;
    logic               r_memwrite;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [31:0]        r_aluout;
    logic [31:0]        r_wdata;
    logic [4:0]         r_wreg;
    logic [c_CNT_W-1:0] r_cnt;

    logic [31:0]        r_mem [0:DEPTH-1];

    logic               w_cand;
    logic               w_is_half;
    logic               w_is_word;
    logic               w_misalign;
    logic               w_memop;
    logic               w_busy;
    logic [c_ADDR_W-1:0] w_idx;
    logic [1:0]         w_off;
    logic [31:0]        w_rword;
    logic [7:0]         w_rbyte;
    logic [15:0]        w_rhalf;
    logic [31:0]        w_ext;
    logic [3:0]         w_be;
    logic [31:0]        w_wlane;

    // Size 11 behaves as a word access.
    assign w_is_half  = (r_size == 2'b01);
    assign w_is_word  = r_size[1];
    assign w_off      = r_aluout[1:0];
    assign w_cand     = r_memtoreg | r_memwrite;
    assign w_misalign = w_cand & ((w_is_half & w_off[0]) |
                                  (w_is_word & (w_off != 2'b00)));
    assign w_memop    = w_cand & ~w_misalign;
    // Depends on M state only, so there is no path from E inputs to the stall.
    assign w_busy     = w_memop & (r_cnt != c_LAT_MAX);

    // Higher address bits are ignored: addresses wrap modulo 4*DEPTH bytes.
    assign w_idx      = r_aluout[c_ADDR_W+1:2];

    // ------------------------------------------------------------------
    // Pipeline register and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_aluout   <= 32'd0;
            r_wdata    <= 32'd0;
            r_wreg     <= 5'd0;
        end else if (!w_busy) begin
            // Hold wins over flush: this branch is only reached when not busy.
            r_regwrite <= RegWriteE & ~FlushM;
            r_memtoreg <= MemtoRegE & ~FlushM;
            r_memwrite <= MemWriteE & ~FlushM;
            r_size     <= MemSizeE;
            r_signed   <= MemSignedE;
            r_aluout   <= ALUOutE;
            r_wdata    <= WriteDataE;
            r_wreg     <= WriteRegE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end else begin
            r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Store path: lane enables and replicated lane data
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = r_wdata;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    // Commits on the closing edge of the access; a reset on that edge
    // abandons the store.
    always_ff @(posedge CLK) begin
        if (!RST && w_memop && r_memwrite && !w_busy) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: combinational read, lane select, extension
    // ------------------------------------------------------------------
    assign w_rword = r_mem[w_idx];
    assign w_rbyte = w_rword[{w_off, 3'b000} +: 8];
    assign w_rhalf = w_off[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_ext = w_rword;
        case (r_size)
            2'b00:   w_ext = {{24{r_signed & w_rbyte[7]}}, w_rbyte};
            2'b01:   w_ext = {{16{r_signed & w_rhalf[15]}}, w_rhalf};
            default: w_ext = w_rword;
        endcase
    end

    assign RD        = (r_memtoreg & ~w_misalign) ? w_ext : 32'd0;
    assign RegWriteM = r_regwrite;
    assign MemtoRegM = r_memtoreg;
    assign ALUOutM   = r_aluout;
    assign WriteRegM = r_wreg;
    assign MemBusy   = w_busy;
    assign MisalignM = w_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ext
// Description : Directed self-checking bench for mem_stage_ext. Three
//               instances (LATENCY 0, 2 and 3) share the E-side stimulus;
//               each scenario checks the instance it is aimed at and starts
//               from a reset pulse so the instances are back in step.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite_e, memtoreg_e, memwrite_e, signed_e, flush_m;
    logic [1:0]  size_e;
    logic [31:0] aluout_e, wdata_e;
    logic [4:0]  wreg_e;

    logic        l0_rw, l0_m2r, l0_busy, l0_mis;
    logic [31:0] l0_alu, l0_rd;
    logic [4:0]  l0_wreg;
    logic        l2_rw, l2_m2r, l2_busy, l2_mis;
    logic [31:0] l2_alu, l2_rd;
    logic [4:0]  l2_wreg;
    logic        l3_rw, l3_m2r, l3_busy, l3_mis;
    logic [31:0] l3_alu, l3_rd;
    logic [4:0]  l3_wreg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_ext #(.DEPTH(256), .LATENCY(0)) u_l0 (
        .CLK(clk), .RST(rst), .RegWriteE(regwrite_e), .MemtoRegE(memtoreg_e),
        .MemWriteE(memwrite_e), .MemSizeE(size_e), .MemSignedE(signed_e),
        .ALUOutE(aluout_e), .WriteDataE(wdata_e), .WriteRegE(wreg_e),
        .FlushM(flush_m), .RegWriteM(l0_rw), .MemtoRegM(l0_m2r),
        .ALUOutM(l0_alu), .WriteRegM(l0_wreg), .RD(l0_rd),
        .MemBusy(l0_busy), .MisalignM(l0_mis)
    );

    mem_stage_ext #(.DEPTH(256), .LATENCY(2)) u_l2 (
        .CLK(clk), .RST(rst), .RegWriteE(regwrite_e), .MemtoRegE(memtoreg_e),
        .MemWriteE(memwrite_e), .MemSizeE(size_e), .MemSignedE(signed_e),
        .ALUOutE(aluout_e), .WriteDataE(wdata_e), .WriteRegE(wreg_e),
        .FlushM(flush_m), .RegWriteM(l2_rw), .MemtoRegM(l2_m2r),
        .ALUOutM(l2_alu), .WriteRegM(l2_wreg), .RD(l2_rd),
        .MemBusy(l2_busy), .MisalignM(l2_mis)
    );

    mem_stage_ext #(.DEPTH(256), .LATENCY(3)) u_l3 (
        .CLK(clk), .RST(rst), .RegWriteE(regwrite_e), .MemtoRegE(memtoreg_e),
        .MemWriteE(memwrite_e), .MemSizeE(size_e), .MemSignedE(signed_e),
        .ALUOutE(aluout_e), .WriteDataE(wdata_e), .WriteRegE(wreg_e),
        .FlushM(flush_m), .RegWriteM(l3_rw), .MemtoRegM(l3_m2r),
        .ALUOutM(l3_alu), .WriteRegM(l3_wreg), .RD(l3_rd),
        .MemBusy(l3_busy), .MisalignM(l3_mis)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rw, input logic m2r, input logic mw,
                          input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] wr);
        regwrite_e = rw;
        memtoreg_e = m2r;
        memwrite_e = mw;
        size_e     = sz;
        signed_e   = sg;
        aluout_e   = addr;
        wdata_e    = wd;
        wreg_e     = wr;
        flush_m    = 1'b0;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic reset_pulse();
        nop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        set_op(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 32'h1234_5673, 32'hFFFF_FFFF, 5'h1F);
        flush_m = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (l0_rw !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b expected 0", l0_rw); end
        checks++; if (l0_m2r !== 1'b0) begin errors++; $display("FAIL reset_memtoreg: got %b expected 0", l0_m2r); end
        checks++; if (l0_alu !== 32'd0) begin errors++; $display("FAIL reset_aluout: got %h expected 00000000", l0_alu); end
        checks++; if (l0_wreg !== 5'd0) begin errors++; $display("FAIL reset_writereg: got %h expected 00", l0_wreg); end
        checks++; if (l0_rd !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h expected 00000000", l0_rd); end
        checks++; if (l0_mis !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", l0_mis); end
        checks++; if (l3_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_l3: got %b expected 0", l3_busy); end
        checks++; if (u_l3.r_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt_l3: got %0d expected 0", u_l3.r_cnt); end
        // Release with a flush: the bubble must not write a register.
        rst = 1'b0;
        tick();
        checks++; if (l0_rw !== 1'b0) begin errors++; $display("FAIL flush_regwrite: got %b expected 0", l0_rw); end
        checks++; if (l2_m2r !== 1'b0) begin errors++; $display("FAIL flush_memtoreg: got %b expected 0", l2_m2r); end
        checks++; if (l0_alu !== 32'h1234_5673) begin errors++; $display("FAIL flush_aluout: got %h expected 12345673", l0_alu); end
        checks++; if (l0_wreg !== 5'h1F) begin errors++; $display("FAIL flush_writereg: got %h expected 1f", l0_wreg); end
        checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_l2: got %b expected 0", l2_busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_word_l0();
        reset_pulse();
        set_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0);
        tick();
        checks++; if (l0_busy !== 1'b0) begin errors++; $display("FAIL word_sw_busy: got %b expected 0", l0_busy); end
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd5);
        tick();
        checks++; if (l0_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_lw_rd: got %h expected deadbeef", l0_rd); end
        checks++; if (l0_busy !== 1'b0) begin errors++; $display("FAIL word_lw_busy: got %b expected 0", l0_busy); end
        checks++; if (l0_wreg !== 5'd5) begin errors++; $display("FAIL word_lw_writereg: got %h expected 05", l0_wreg); end
        checks++; if (l0_rw !== 1'b1) begin errors++; $display("FAIL word_lw_regwrite: got %b expected 1", l0_rw); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_subword_l0();
        reset_pulse();
        set_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 5'd0);
        tick();
        set_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_0080, 5'd0);
        tick();
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 5'd6);
        tick();
        checks++; if (l0_rd !== 32'h8022_3344) begin errors++; $display("FAIL sub_lw_after_sb: got %h expected 80223344", l0_rd); end
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'd0, 5'd6);
        tick();
        checks++; if (l0_rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL sub_lb: got %h expected ffffff80", l0_rd); end
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'd0, 5'd6);
        tick();
        checks++; if (l0_rd !== 32'h0000_0080) begin errors++; $display("FAIL sub_lbu: got %h expected 00000080", l0_rd); end
        set_op(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 5'd6);
        tick();
        checks++; if (l0_rd !== 32'hFFFF_8022) begin errors++; $display("FAIL sub_lh: got %h expected ffff8022", l0_rd); end
        checks++; if (l0_mis !== 1'b0) begin errors++; $display("FAIL sub_lh_misalign: got %b expected 0", l0_mis); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_misalign();
        reset_pulse();
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h06, 32'd0, 5'd4);
        tick();
        checks++; if (l2_mis !== 1'b1) begin errors++; $display("FAIL mis_lw_flag: got %b expected 1", l2_mis); end
        checks++; if (l2_rd !== 32'd0) begin errors++; $display("FAIL mis_lw_rd: got %h expected 00000000", l2_rd); end
        checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL mis_lw_busy: got %b expected 0", l2_busy); end
        set_op(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_BEEF, 5'd0);
        tick();
        checks++; if (l2_mis !== 1'b1) begin errors++; $display("FAIL mis_sh_flag: got %b expected 1", l2_mis); end
        checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL mis_sh_busy: got %b expected 0", l2_busy); end
        // 0x10 on the LATENCY-0 instance still holds the earlier word.
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd4);
        tick();
        checks++; if (l0_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mis_sh_nowrite: got %h expected deadbeef", l0_rd); end
        checks++; if (l0_mis !== 1'b0) begin errors++; $display("FAIL mis_aligned_flag: got %b expected 0", l0_mis); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_latency_l2();
        reset_pulse();
        set_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5_5A5A, 5'd0);
        tick();
        checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL lat_sw_busy0: got %b expected 1", l2_busy); end
        nop();
        tick();
        tick();
        checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL lat_sw_done: got %b expected 0", l2_busy); end
        // Load enters M on the edge the store completes.
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 5'd7);
        tick();
        checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL lat_lw_busy1: got %b expected 1", l2_busy); end
        checks++; if (l2_alu !== 32'h30) begin errors++; $display("FAIL lat_lw_alu1: got %h expected 00000030", l2_alu); end
        // Change E and pulse flush while busy: both must be ignored.
        set_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h999, 32'd0, 5'd9);
        flush_m = 1'b1;
        tick();
        checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL lat_lw_busy2: got %b expected 1", l2_busy); end
        checks++; if (l2_alu !== 32'h30) begin errors++; $display("FAIL lat_lw_alu2: got %h expected 00000030", l2_alu); end
        checks++; if (l2_wreg !== 5'd7) begin errors++; $display("FAIL lat_lw_wreg2: got %h expected 07", l2_wreg); end
        flush_m = 1'b0;
        tick();
        checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL lat_lw_busy3: got %b expected 0", l2_busy); end
        checks++; if (l2_rd !== 32'hA5A5_5A5A) begin errors++; $display("FAIL lat_lw_rd: got %h expected a5a55a5a", l2_rd); end
        checks++; if (l2_rw !== 1'b1) begin errors++; $display("FAIL lat_lw_regwrite: got %b expected 1", l2_rw); end
        checks++; if (l2_m2r !== 1'b1) begin errors++; $display("FAIL lat_lw_memtoreg: got %b expected 1", l2_m2r); end
        tick();
        checks++; if (l2_alu !== 32'h999) begin errors++; $display("FAIL lat_next_alu: got %h expected 00000999", l2_alu); end
        checks++; if (l2_wreg !== 5'd9) begin errors++; $display("FAIL lat_next_wreg: got %h expected 09", l2_wreg); end
        checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL lat_next_busy: got %b expected 0", l2_busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_l3();
        reset_pulse();
        set_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 5'd0);
        tick();
        nop();
        for (int i = 0; i < 5; i++) tick();
        set_op(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 5'd0);
        tick();
        nop();
        tick();
        checks++; if (l3_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", l3_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (l3_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b expected 0", l3_busy); end
        checks++; if (u_l3.r_cnt !== 2'd0) begin errors++; $display("FAIL mid_cnt_after: got %0d expected 0", u_l3.r_cnt); end
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 5'd3);
        tick();
        checks++; if (l3_busy !== 1'b1) begin errors++; $display("FAIL mid_lw_busy: got %b expected 1", l3_busy); end
        nop();
        tick();
        tick();
        tick();
        checks++; if (l3_busy !== 1'b0) begin errors++; $display("FAIL mid_lw_done: got %b expected 0", l3_busy); end
        checks++; if (l3_rd !== 32'h1234_5678) begin errors++; $display("FAIL mid_lw_rd: got %h expected 12345678", l3_rd); end
    endtask

    initial begin
        rst = 1'b1;
        nop();
        test_reset();
        test_word_l0();
        test_subword_l0();
        test_misalign();
        test_latency_l2();
        test_reset_mid_l3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ext.md
# mem_stage_ext

Parametrised MEM pipeline stage for the pipelined MIPS core. It replaces the single-cycle word-only stage. It holds the E→M pipeline register and a DEPTH-word data memory, and adds:
- byte, halfword and word loads/stores, with sign or zero extension on loads;
- a configurable multi-cycle memory latency, with a stall request back to the earlier stages;
- bubble insertion (flush);
- misalignment detection.

It sits between the execute stage and the writeback stage.

## Interface
Parameters:
- DEPTH, 256, data memory size in 32-bit words; power of two, ≥4.
- LATENCY, 0, extra cycles each aligned memory access occupies in M; range 0..7.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  control bits from E.
- MemSizeE  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- MemSignedE  in  1  1 = sign-extend loads, 0 = zero-extend.
- ALUOutE  in  32  effective address, or ALU result for non-memory ops.
- WriteDataE  in  32  store data, right-aligned.
- WriteRegE  in  5  destination register.
- FlushM  in  1  load a bubble into the M register instead of the E values.
- RegWriteM, MemtoRegM  out  1 each  registered control bits to W.
- ALUOutM  out  32  registered address/result.
- WriteRegM  out  5  registered destination register.
- RD  out  32  extended load data.
- MemBusy  out  1  stall request: E-side inputs are not accepted this cycle.
- MisalignM  out  1  the instruction in M is a misaligned access.

## Operation
- M register fields: RegWrite, MemtoReg, MemWrite, MemSize, MemSigned, ALUOut, WriteData, WriteReg.
- Register update at each edge:
  - If MemBusy=1, all fields hold.
  - Otherwise, if FlushM=1, RegWrite, MemtoReg and MemWrite load 0; the other fields load their E values.
  - Otherwise, all fields load their E values.
- Memory operation: memop = (MemtoRegM | MemWriteM) & ~MisalignM.
- Misalignment:
  - MisalignM = memop-candidate & ((size half & ALUOutM[0]) | (size word & ALUOutM[1:0]≠0)).
  - A misaligned store does not write memory.
  - A misaligned load returns RD=0.
  - A misaligned access never asserts MemBusy.
- Addressing:
  - Word index = ALUOutM[clog2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
  - Byte order is little-endian: byte offset 0 is bits [7:0].
- Loads: the memory read is combinational from the array. The selected lane (byte at offset a[1:0], half at a[1]) is sign- or zero-extended to 32 bits. RD is 0 when MemtoRegM=0.
- Stores: write only the lanes selected by size and offset, using WriteData[7:0] for byte and WriteData[15:0] for half. Unselected lanes are unchanged.
- Latency counter cnt, width clog2(LATENCY+1), reset 0:
  - MemBusy = memop & (cnt ≠ LATENCY).
  - While MemBusy=1, cnt increments each edge.
  - In the cycle where cnt == LATENCY, the access completes: RD is valid, the store commits at the closing edge, the M register advances and cnt returns to 0.
  - With LATENCY=0, MemBusy is constantly 0 and every access takes one cycle.
- FlushM while MemBusy=1 is ignored; hold has priority over flush.
- Memory array contents are not reset.

## Timing
- Reset values: RegWriteM=0, MemtoRegM=0, ALUOutM=0, WriteRegM=0, RD=0, MemBusy=0, MisalignM=0, cnt=0. The internal MemWrite, MemSize, MemSigned and WriteData fields are 0.
- RST asserted during a busy access abandons it: the pending store is dropped and cnt is cleared on the same edge.
- Occupancy in M: an aligned memory op stays in M for exactly LATENCY+1 cycles. A non-memory or misaligned op stays for 1 cycle.
- Back-to-back memory ops: the second op starts its count on the edge the first one completes. There are no idle cycles between them.
- Store-then-load to the same address: the load in the next M cycle sees the stored data. The write at the edge precedes the combinational read.
- MemBusy depends only on M-register state and cnt, never on E inputs. There is no combinational path from E inputs to MemBusy.

## Test plan
- Reset: drive all inputs nonzero with RST=1 for 2 cycles → every output is 0 and MemBusy=0. After release, a single flush cycle still gives RegWriteM=0.
- LATENCY=0, word round-trip: sw 0xDEADBEEF to 0x10, then lw 0x10 → RD=0xDEADBEEF in the load's M cycle; MemBusy stays 0.
- Sub-word access:
  - sw 0x11223344 to 0x20, then sb 0x80 to 0x23, then lw 0x20 → 0x80223344.
  - lb 0x23 → 0xFFFFFF80; lbu 0x23 → 0x00000080.
  - lh 0x22 → 0xFFFF8022.
- LATENCY=2, load with changing E inputs:
  - MemBusy=1 for exactly 2 cycles; ALUOutM and WriteRegM hold.
  - RD is valid in the 3rd cycle.
  - The next E op is captured on the following edge.
  - A FlushM pulse during the busy cycles has no effect.
- Misalignment:
  - lw 0x06 → MisalignM=1, RD=0, MemBusy=0.
  - sh 0x11 with data 0xBEEF → memory unchanged, verified by a later aligned lw.
- Reset mid-access: LATENCY=3, sw 0xCAFEF00D to 0x40, assert RST in the 2nd busy cycle → cnt=0 and MemBusy=0. A later lw 0x40 returns the old value.
